// File: rtl/updown_counter_param_if.sv
// Control/status bundle for updown_counter_param.
// master: the driver side. It drives enable/load/data/direction/flag-clear and
//         observes count and flags.
// slave : the counter side. It receives the controls and drives count and flags.
// Signals:
//   enable_i, load_i, up_dn_i, clr_flag_i : 1-bit controls
//   data_i [WIDTH]                        : parallel load value
//   count_o [WIDTH]                       : registered count
//   even_o, tc_o                          : combinational status derived from count_o
//   wrap_o, ovf_sticky_o                  : registered bound-event flags
interface updown_counter_param_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             enable_i;
    logic             load_i;
    logic [WIDTH-1:0] data_i;
    logic             up_dn_i;
    logic             clr_flag_i;
    logic [WIDTH-1:0] count_o;
    logic             even_o;
    logic             tc_o;
    logic             wrap_o;
    logic             ovf_sticky_o;

    modport master (
        output enable_i,
        output load_i,
        output data_i,
        output up_dn_i,
        output clr_flag_i,
        input  count_o,
        input  even_o,
        input  tc_o,
        input  wrap_o,
        input  ovf_sticky_o
    );

    modport slave (
        input  enable_i,
        input  load_i,
        input  data_i,
        input  up_dn_i,
        input  clr_flag_i,
        output count_o,
        output even_o,
        output tc_o,
        output wrap_o,
        output ovf_sticky_o
    );

endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate bounds, terminal count
// and bound-event flags.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active-high (count -> RESET_VAL, flags -> 0)
//   bus   : updown_counter_param_if.slave
//           (enable_i, load_i, data_i, up_dn_i, clr_flag_i in;
//            count_o, even_o, tc_o, wrap_o, ovf_sticky_o out)
// Priority per edge: reset > load > enable > hold.
// A "bound event" is an enabled count step taken while already at the bound in
// the current direction (MAX_VAL going up, 0 going down).
module updown_counter_param #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input logic                  clk_i,
    input logic                  rst_i,
    updown_counter_param_if.slave bus
);

    // Catch illegal configurations at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be >= 2");
    end
    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
        $error("updown_counter_param: MAX_VAL out of range");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("updown_counter_param: RESET_VAL exceeds MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] Zero     = '0;
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sticky_q, sticky_d;
    logic             bound_event;

    // Next-state: load clamps to the legal range; counting stops or wraps at the
    // bounds so the count never leaves 0..MAX_VAL even when MAX_VAL < 2**WIDTH-1.
    always_comb begin
        count_d     = count_q;
        bound_event = 1'b0;
        if (bus.load_i) begin
            count_d = (bus.data_i > MaxVal) ? MaxVal : bus.data_i;
        end else if (bus.enable_i) begin
            if (bus.up_dn_i) begin
                // >= rather than == keeps the counter recoverable from any
                // out-of-range value.
                if (count_q >= MaxVal) begin
                    bound_event = 1'b1;
                    count_d     = SATURATE ? MaxVal : Zero;
                end else begin
                    count_d = count_q + One;
                end
            end else begin
                if (count_q == Zero) begin
                    bound_event = 1'b1;
                    count_d     = SATURATE ? Zero : MaxVal;
                end else begin
                    count_d = count_q - One;
                end
            end
        end
    end

    // Set has priority over clear so a bound event coinciding with a clear is
    // not lost.
    always_comb begin
        wrap_d   = bound_event;
        sticky_d = bound_event | (sticky_q & ~bus.clr_flag_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= ResetVal;
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            sticky_q <= sticky_d;
        end
    end

    // Terminal count tracks direction combinationally, so it flips with up_dn_i
    // in the same cycle.
    always_comb begin
        bus.count_o      = count_q;
        bus.even_o       = ~count_q[0];
        bus.tc_o         = bus.up_dn_i ? (count_q == MaxVal) : (count_q == Zero);
        bus.wrap_o       = wrap_q;
        bus.ovf_sticky_o = sticky_q;
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param. Three instances share one stimulus stream:
//   d0: WIDTH=4 MAX_VAL=9 wrap,     RESET_VAL=2
//   d1: WIDTH=4 MAX_VAL=9 saturate, RESET_VAL=0
//   d2: WIDTH=3 defaults (MAX_VAL=7) wrap, RESET_VAL=0
// Expected values come from a modular-arithmetic / clamp model of each instance.
module tb_updown_counter_param;

    localparam int N = 3;
    localparam int MAXV [N] = '{9, 9, 7};
    localparam int SATV [N] = '{0, 1, 0};
    localparam int RSTV [N] = '{2, 0, 0};
    localparam int MASK [N] = '{15, 15, 7};

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, load, up_dn, clr_flag;
    logic [3:0] data;

    int total = 0;
    int bad   = 0;

    int m_cnt    [N];
    int m_wrap   [N];
    int m_sticky [N];

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(4)) bus0 ();
    updown_counter_param_if #(.WIDTH(4)) bus1 ();
    updown_counter_param_if #(.WIDTH(3)) bus2 ();

    assign bus0.enable_i = enable;   assign bus1.enable_i = enable;   assign bus2.enable_i = enable;
    assign bus0.load_i = load;       assign bus1.load_i = load;       assign bus2.load_i = load;
    assign bus0.up_dn_i = up_dn;     assign bus1.up_dn_i = up_dn;     assign bus2.up_dn_i = up_dn;
    assign bus0.clr_flag_i = clr_flag;
    assign bus1.clr_flag_i = clr_flag;
    assign bus2.clr_flag_i = clr_flag;
    assign bus0.data_i = data;
    assign bus1.data_i = data;
    assign bus2.data_i = data[2:0];

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RESET_VAL(2)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .RESET_VAL(0)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    updown_counter_param #(.WIDTH(3)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    function automatic logic [31:0] obs(input int i, input int what);
        logic [4:0] v0, v1, v2;
        v0 = {bus0.count_o[0] ? 1'b0 : 1'b0, bus0.count_o} ;
        v1 = {1'b0, bus1.count_o};
        v2 = {2'b0, bus2.count_o};
        case (what)
            0: return (i == 0) ? 32'(v0) : (i == 1) ? 32'(v1) : 32'(v2);
            1: return (i == 0) ? 32'(bus0.even_o) : (i == 1) ? 32'(bus1.even_o) : 32'(bus2.even_o);
            2: return (i == 0) ? 32'(bus0.tc_o) : (i == 1) ? 32'(bus1.tc_o) : 32'(bus2.tc_o);
            3: return (i == 0) ? 32'(bus0.wrap_o) : (i == 1) ? 32'(bus1.wrap_o) : 32'(bus2.wrap_o);
            default: return (i == 0) ? 32'(bus0.ovf_sticky_o) :
                            (i == 1) ? 32'(bus1.ovf_sticky_o) : 32'(bus2.ovf_sticky_o);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]    = RSTV[i];
            m_wrap[i]   = 0;
            m_sticky[i] = 0;
        end
    endtask

    // One rising edge of the reference: clamped load, modular or clamped step.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int mx, c, nxt, ev, d;
            mx  = MAXV[i];
            c   = m_cnt[i];
            nxt = c;
            ev  = 0;
            if (load) begin
                d   = int'(data) & MASK[i];
                nxt = (d < mx) ? d : mx;
            end else if (enable) begin
                if (up_dn) begin
                    ev  = (c == mx) ? 1 : 0;
                    nxt = SATV[i] ? ((c + 1 > mx) ? mx : c + 1) : (c + 1) % (mx + 1);
                end else begin
                    ev  = (c == 0) ? 1 : 0;
                    nxt = SATV[i] ? ((c == 0) ? 0 : c - 1) : (c + mx) % (mx + 1);
                end
            end
            m_cnt[i]    = nxt;
            m_wrap[i]   = ev;
            m_sticky[i] = ev ? 1 : (clr_flag ? 0 : m_sticky[i]);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            int mx;
            mx = MAXV[i];
            check($sformatf("%s d%0d count", tag, i), obs(i, 0), 32'(m_cnt[i]));
            check($sformatf("%s d%0d even", tag, i), obs(i, 1), 32'((m_cnt[i] % 2) == 0));
            check($sformatf("%s d%0d tc", tag, i), obs(i, 2),
                  32'(up_dn ? (m_cnt[i] == mx) : (m_cnt[i] == 0)));
            check($sformatf("%s d%0d wrap", tag, i), obs(i, 3), 32'(m_wrap[i]));
            check($sformatf("%s d%0d sticky", tag, i), obs(i, 4), 32'(m_sticky[i]));
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_edge();
        check_all(tag);
    endtask

    task automatic set_in(input logic en, input logic ld, input logic up, input logic clr,
                          input logic [3:0] d);
        enable   = en;
        load     = ld;
        up_dn    = up;
        clr_flag = clr;
        data     = d;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        model_reset();
        #1;
        check_all("reset");
        check("reset d0 count const", 32'(bus0.count_o), 32'd2);
        #2;
        rst = 1'b0;

        // 1: wrap-mode up count 0..9,0
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick("t1 load0");
        check("t1 d0 even at 0", 32'(bus0.even_o), 32'd1);
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 9; k++) tick($sformatf("t1 up%0d", k));
        check("t1 d0 count 9", 32'(bus0.count_o), 32'd9);
        check("t1 d0 tc at 9", 32'(bus0.tc_o), 32'd1);
        tick("t1 up10");
        check("t1 d0 wrapped to 0", 32'(bus0.count_o), 32'd0);
        check("t1 d0 wrap pulse", 32'(bus0.wrap_o), 32'd1);
        check("t1 d0 sticky", 32'(bus0.ovf_sticky_o), 32'd1);
        tick("t1 up11");
        check("t1 d0 wrap one cycle", 32'(bus0.wrap_o), 32'd0);

        // 2: down from 0, then direction change flips tc without a clock
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick("t2 load0");
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick("t2 dn1");
        check("t2 d0 down wraps to 9", 32'(bus0.count_o), 32'd9);
        check("t2 d0 wrap at 9", 32'(bus0.wrap_o), 32'd1);
        tick("t2 dn2");
        tick("t2 dn3");
        check("t2 d0 count 7", 32'(bus0.count_o), 32'd7);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick("t2 load0b");
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        #1;
        check("t2 d0 tc down at 0", 32'(bus0.tc_o), 32'd1);
        up_dn = 1'b1;
        #1;
        check("t2 d0 tc after dir flip", 32'(bus0.tc_o), 32'd0);
        check_all("t2 flip");

        // 3: saturate mode at both bounds
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd7);
        tick("t3 load7");
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            tick($sformatf("t3 up%0d", k));
            check($sformatf("t3 d1 up%0d wrap", k), 32'(bus1.wrap_o), (k >= 3) ? 32'd1 : 32'd0);
        end
        check("t3 d1 held at 9", 32'(bus1.count_o), 32'd9);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        tick("t3 load1");
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 1; k <= 3; k++) begin
            tick($sformatf("t3 dn%0d", k));
            check($sformatf("t3 d1 dn%0d wrap", k), 32'(bus1.wrap_o), (k >= 2) ? 32'd1 : 32'd0);
        end
        check("t3 d1 held at 0", 32'(bus1.count_o), 32'd0);

        // 4: load clamps and beats enable
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd13);
        tick("t4 load13");
        check("t4 d0 clamped 9", 32'(bus0.count_o), 32'd9);
        check("t4 d0 no wrap on load", 32'(bus0.wrap_o), 32'd0);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd4);
        tick("t4 load+en");
        check("t4 d0 load wins", 32'(bus0.count_o), 32'd4);
        check("t4 d1 no wrap on load", 32'(bus1.wrap_o), 32'd0);

        // 5: sticky clear, and set beating a simultaneous clear
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        tick("t5 clr");
        check("t5 d0 sticky cleared", 32'(bus0.ovf_sticky_o), 32'd0);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
        tick("t5 load9");
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick("t5 wrap+clr");
        check("t5 d0 set wins", 32'(bus0.ovf_sticky_o), 32'd1);
        check("t5 d0 wrap", 32'(bus0.wrap_o), 32'd1);

        // 6: asynchronous reset mid-count
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
        tick("t6 load4");
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        tick("t6 up5");
        tick("t6 up6");
        check("t6 d0 at 6", 32'(bus0.count_o), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6 d0 async reset value", 32'(bus0.count_o), 32'd2);
        check_all("t6 async");
        tick("t6 held in reset");
        #2;
        rst = 1'b0;
        tick("t6 resume");
        check("t6 d0 resumes from 2", 32'(bus0.count_o), 32'd3);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom_range(3) != 0), ($urandom_range(7) == 0), 1'(($urandom_range(1))),
                   ($urandom_range(7) == 0), 4'($urandom_range(15)));
            tick($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
